// File: rtl/wb_initiator.sv
// Wishbone classic initiator: turns single 68k-style byte/word/long requests into
// big-endian bus cycles, splitting 2-aligned longs and reporting bus/timeout/address errors.
module wb_initiator #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic [AW-1:0] req_adr,
  input  logic [31:0]   req_dat,
  output logic          rsp_valid,
  output logic [1:0]    rsp_code,
  output logic [31:0]   rsp_dat,
  output logic [AW-1:0] ADR_O,
  output logic [31:0]   DAT_O,
  input  logic [31:0]   DAT_I,
  output logic [3:0]    SEL_O,
  output logic          WE_O,
  output logic          CYC_O,
  output logic          STB_O,
  input  logic          ACK_I,
  input  logic          ERR_I
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  localparam logic [1:0] RSP_OK     = 2'b00;
  localparam logic [1:0] RSP_BUSERR = 2'b01;
  localparam logic [1:0] RSP_TMO    = 2'b10;
  localparam logic [1:0] RSP_ADRERR = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS1, BUS2, RESP} state_t;

  state_t        state_q, state_d;
  logic          run_q, run_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic          split_q, split_d;
  logic [15:0]   wlo_q, wlo_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [1:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      wlo_q   <= '0;
      size_q  <= '0;
      off_q   <= '0;
      rdat_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      split_q <= split_d;
      wlo_q   <= wlo_d;
      size_q  <= size_d;
      off_q   <= off_d;
      rdat_q  <= rdat_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    we_d    = we_q;
    split_d = split_q;
    wlo_d   = wlo_q;
    size_d  = size_q;
    off_d   = off_q;
    rdat_d  = rdat_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          size_d  = req_size;
          off_d   = req_adr[1:0];
          we_d    = req_we;
          adr_d   = {req_adr[AW-1:2], 2'b00};
          wlo_d   = req_dat[15:0];
          split_d = 1'b0;
          rdat_d  = '0;
          cnt_d   = '0;
          code_d  = RSP_OK;
          state_d = BUS1;
          // Big-endian lanes: offset 0 lives in DAT[31:24]
          case (req_size)
            SZ_BYTE: begin
              sel_d = 4'b1000 >> req_adr[1:0];
              dat_d = {24'h0, req_dat[7:0]} << {~req_adr[1:0], 3'b000};
            end
            SZ_WORD: begin
              sel_d = req_adr[1] ? 4'b0011 : 4'b1100;
              dat_d = req_adr[1] ? {16'h0, req_dat[15:0]} : {req_dat[15:0], 16'h0};
            end
            default: begin
              split_d = req_adr[1];
              sel_d   = req_adr[1] ? 4'b0011 : 4'b1111;
              dat_d   = req_adr[1] ? {16'h0, req_dat[31:16]} : req_dat;
            end
          endcase
          if (req_size == 2'b11 || (req_size != SZ_BYTE && req_adr[0])) begin
            state_d = RESP;
            code_d  = RSP_ADRERR;
            split_d = 1'b0;
          end
        end
      end
      BUS1, BUS2: begin
        if (ERR_I) begin
          state_d = RESP;
          code_d  = RSP_BUSERR;
          rdat_d  = '0;
          cnt_d   = '0;
        end else if (ACK_I) begin
          if (!we_q) begin
            case (size_q)
              SZ_BYTE: rdat_d = {24'h0, 8'(DAT_I >> {~off_q, 3'b000})};
              SZ_WORD: rdat_d = {16'h0, off_q[1] ? DAT_I[15:0] : DAT_I[31:16]};
              default: begin
                if (!split_q)            rdat_d         = DAT_I;
                else if (state_q == BUS1) rdat_d[31:16] = DAT_I[15:0];
                else                      rdat_d[15:0]  = DAT_I[31:16];
              end
            endcase
          end
          cnt_d = '0;
          if (state_q == BUS1 && split_q) begin
            state_d = BUS2;
            adr_d   = adr_q + AW'(4);
            sel_d   = 4'b1100;
            dat_d   = {wlo_q, 16'h0};
          end else begin
            state_d = RESP;
            code_d  = RSP_OK;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          code_d  = RSP_TMO;
          rdat_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are parked at zero whenever no cycle is in progress
  assign CYC_O     = (state_q == BUS1) || (state_q == BUS2);
  assign STB_O     = CYC_O;
  assign WE_O      = CYC_O && we_q;
  assign SEL_O     = CYC_O ? sel_q : 4'h0;
  assign ADR_O     = CYC_O ? adr_q : '0;
  assign DAT_O     = (CYC_O && we_q) ? dat_q : 32'h0;
  assign req_ready = run_q && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_code  = code_q;
  assign rsp_dat   = rdat_q;

endmodule
